// File: rtl/popcount_seq_if.sv
// Handshake bundle for popcount_seq: an input word channel and a result channel.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface popcount_seq_if #(
    parameter int WIDTH = 64,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_data, in_acc, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_acc, in_last, out_ready,
        output in_ready, out_valid, out_count, out_sat
    );
endinterface

// File: rtl/popcount_seq.sv
// Multi-cycle population counter: counts CHUNK bits of a WIDTH-bit word per cycle,
// with an optional saturating accumulate mode that sums counts over a packet.
module popcount_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int ACC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    popcount_seq_if.slave      bus,
    output logic [1:0]         state_dbg
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = $clog2(CHUNK + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic             acc_mode;
    logic             last_word;

    logic [CNT_W-1:0] node [CHUNK];
    logic [CNT_W-1:0] chunk_cnt;
    logic [ACC_W:0]   sum;
    logic             sat_hit;
    logic [ACC_W-1:0] acc_next;
    logic             sat_next;

    assign state_dbg = state;

    // Pairwise reduction tree over the low chunk; node[0] ends up holding the total.
    always_comb begin
        for (int i = 0; i < CHUNK; i++) begin
            node[i] = CNT_W'(sreg[i]);
        end
        for (int step = 1; step < CHUNK; step = step * 2) begin
            for (int i = 0; i + step < CHUNK; i = i + 2 * step) begin
                node[i] = node[i] + node[i + step];
            end
        end
        chunk_cnt = node[0];
    end

    // One spare bit on the sum detects overflow; the accumulator then clamps to all-ones.
    always_comb begin
        sum      = {1'b0, acc} + (ACC_W + 1)'(chunk_cnt);
        sat_hit  = sum[ACC_W];
        acc_next = sat_hit ? '1 : sum[ACC_W-1:0];
        sat_next = sat | sat_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            sreg          <= '0;
            idx           <= '0;
            acc           <= '0;
            sat           <= 1'b0;
            acc_mode      <= 1'b0;
            last_word     <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_count <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg         <= bus.in_data;
                        acc_mode     <= bus.in_acc;
                        last_word    <= bus.in_last;
                        idx          <= '0;
                        // A single word drops any partial packet total.
                        if (!bus.in_acc) begin
                            acc <= '0;
                            sat <= 1'b0;
                        end
                        bus.in_ready <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc_next;
                    sat  <= sat_next;
                    sreg <= sreg >> CHUNK;
                    idx  <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N - 1)) begin
                        if (acc_mode && !last_word) begin
                            bus.in_ready <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            bus.out_valid <= 1'b1;
                            bus.out_count <= acc_next;
                            bus.out_sat   <= sat_next;
                            state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        acc           <= '0;
                        sat           <= 1'b0;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_seq.sv
// Directed bench for popcount_seq: a 16-bit-accumulator instance for the main vectors
// and a 7-bit-accumulator instance for saturation.
module tb_popcount_seq;
    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int N     = WIDTH / CHUNK;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] st0, st1;

    popcount_seq_if #(.WIDTH(WIDTH), .ACC_W(16)) bus0 ();
    popcount_seq_if #(.WIDTH(WIDTH), .ACC_W(7))  bus1 ();

    popcount_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ACC_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .state_dbg(st0)
    );
    popcount_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ACC_W(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(st1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        sel;
        logic [63:0] data;
        logic        acc;
        logic        last;
        logic        has_out;
        logic [15:0] exp_count;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic sel, input logic [63:0] data, input logic acc,
                           input logic last, input logic has_out, input logic [15:0] cnt,
                           input logic sat);
        vec_t v;
        v.sel = sel; v.data = data; v.acc = acc; v.last = last;
        v.has_out = has_out; v.exp_count = cnt; v.exp_sat = sat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic in_rdy(input logic sel);
        return sel ? bus1.in_ready : bus0.in_ready;
    endfunction
    function automatic logic out_vld(input logic sel);
        return sel ? bus1.out_valid : bus0.out_valid;
    endfunction
    function automatic logic [15:0] out_cnt(input logic sel);
        return sel ? {9'd0, bus1.out_count} : bus0.out_count;
    endfunction
    function automatic logic out_st(input logic sel);
        return sel ? bus1.out_sat : bus0.out_sat;
    endfunction

    task automatic drive(input logic sel, input logic v, input logic [63:0] data,
                         input logic acc, input logic last);
        if (sel) begin
            bus1.in_valid = v; bus1.in_data = data; bus1.in_acc = acc; bus1.in_last = last;
        end else begin
            bus0.in_valid = v; bus0.in_data = data; bus0.in_acc = acc; bus0.in_last = last;
        end
    endtask

    task automatic set_out_ready(input logic sel, input logic v);
        if (sel) bus1.out_ready = v;
        else     bus0.out_ready = v;
    endtask

    // Returns just after the accepting edge (E0 + #1).
    task automatic send(input logic sel, input logic [63:0] data, input logic acc, input logic last);
        int k = 0;
        while (!in_rdy(sel) && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("in_ready_before_send", in_rdy(sel), 1'b1);
        drive(sel, 1'b1, data, acc, last);
        @(posedge clk); #1;
        drive(sel, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic expect_result(input string name, input logic sel, input logic [15:0] cnt,
                                 input logic sat, input int hold);
        int  lat = 0;
        bit  stable = 1'b1;
        while (!out_vld(sel) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, lat, N);
        check({name, "_count"}, out_cnt(sel), cnt);
        check({name, "_sat"}, out_st(sel), sat);
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_vld(sel) || out_cnt(sel) !== cnt || out_st(sel) !== sat || in_rdy(sel))
                stable = 1'b0;
        end
        check({name, "_hold_stable"}, stable, 1'b1);
        set_out_ready(sel, 1'b1);
        @(posedge clk); #1;
        set_out_ready(sel, 1'b0);
        check({name, "_valid_drop"}, out_vld(sel), 1'b0);
        check({name, "_ready_back"}, in_rdy(sel), 1'b1);
    endtask

    task automatic expect_none(input string name, input logic sel);
        bit seen = 1'b0;
        repeat (N) begin
            @(posedge clk); #1;
            if (out_vld(sel)) seen = 1'b1;
        end
        check({name, "_no_valid"}, seen, 1'b0);
        check({name, "_ready_back"}, in_rdy(sel), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        set_out_ready(1'b0, 1'b0);
        set_out_ready(1'b1, 1'b0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready",  bus0.in_ready,  1'b1);
        check("rst_out_valid", bus0.out_valid, 1'b0);
        check("rst_out_count", bus0.out_count, 16'd0);
        check("rst_out_sat",   bus0.out_sat,   1'b0);
        check("rst1_in_ready", bus1.in_ready,  1'b1);

        add_vec(0, 64'hFFFF_0000_FFFF_0001, 0, 0, 1, 16'd33,  0);
        add_vec(0, 64'h0,                   0, 0, 1, 16'd0,   0);
        add_vec(0, ONES,                    0, 0, 1, 16'd64,  0);
        add_vec(0, 64'h8000_0000_0000_0001, 0, 0, 1, 16'd2,   0);
        add_vec(0, ONES,                    1, 0, 0, 16'd0,   0);
        add_vec(0, 64'hF,                   1, 0, 0, 16'd0,   0);
        add_vec(0, 64'h1,                   1, 1, 1, 16'd69,  0);
        add_vec(1, ONES,                    1, 0, 0, 16'd0,   0);
        add_vec(1, ONES,                    1, 0, 0, 16'd0,   0);
        add_vec(1, ONES,                    1, 1, 1, 16'd127, 1);
        add_vec(1, ONES,                    0, 0, 1, 16'd64,  0);
        add_vec(0, 64'hAAAA_AAAA_AAAA_AAAA, 1, 0, 0, 16'd0,   0);
        add_vec(0, 64'h3,                   0, 0, 1, 16'd2,   0);
        add_vec(0, 64'hFF,                  0, 1, 1, 16'd8,   0);

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send(vecs[i].sel, vecs[i].data, vecs[i].acc, vecs[i].last);
            if (vecs[i].has_out)
                expect_result(nm, vecs[i].sel, vecs[i].exp_count, vecs[i].exp_sat, 0);
            else
                expect_none(nm, vecs[i].sel);
        end

        // Backpressure: result held for 10 cycles with out_ready low.
        send(1'b0, ONES, 1'b0, 1'b0);
        expect_result("backpressure", 1'b0, 16'd64, 1'b0, 10);

        // Reset during BUSY of an accumulate word abandons the partial total.
        send(1'b0, 64'hFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready",  bus0.in_ready,  1'b1);
        check("midrst_out_valid", bus0.out_valid, 1'b0);
        check("midrst_out_count", bus0.out_count, 16'd0);
        check("midrst_out_sat",   bus0.out_sat,   1'b0);
        rst_n = 1'b1;
        send(1'b0, 64'h3, 1'b1, 1'b1);
        expect_result("after_rst_acc", 1'b0, 16'd2, 1'b0, 0);
        send(1'b0, 64'h3, 1'b0, 1'b0);
        expect_result("after_rst_single", 1'b0, 16'd2, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
